// File: rtl/multi_rate_divider_pkg.sv
// rtl/multi_rate_divider_pkg.sv - shared constants and helpers for the multi-rate clock divider
package multi_rate_divider_pkg;

    localparam int CNT_W_DEF  = 8;
    localparam int NUM_CH_DEF = 2;
    localparam int NUM_CH_MAX = 8;

    // 5.6448 MHz master: ch0 -> 44.1 kHz (half 64), ch1 -> 176.4 kHz (half 16)
    localparam logic [NUM_CH_DEF*CNT_W_DEF-1:0] DEF_HALF_DEF = {8'd16, 8'd64};

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/multi_rate_divider_div_channel.sv
// rtl/multi_rate_divider_div_channel.sv - one 50%-duty divided clock with tick strobe and deferred ratio update
module div_channel
    import multi_rate_divider_pkg::*;
#(
    parameter int               CNT_W    = CNT_W_DEF,
    parameter logic [CNT_W-1:0] RST_HALF = CNT_W'(64)
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             enable,
    input  logic             sync_req,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_val,
    output logic             clk_out,
    output logic             tick,
    output logic             pend
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] pending;
    logic             terminal;
    logic             apply_edge;

    assign terminal   = (cnt == (half - CNT_W'(1)));
    // Ratio swaps only on the falling toggle so every period has equal halves
    assign apply_edge = enable && terminal && clk_out;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            cnt     <= '0;
            half    <= RST_HALF;
            pending <= RST_HALF;
            clk_out <= 1'b0;
            tick    <= 1'b0;
            pend    <= 1'b0;
        end else begin
            if (sync_req) begin
                cnt     <= '0;
                clk_out <= 1'b0;
                tick    <= 1'b0;
                if (pend) begin
                    half <= pending;
                end
            end else if (enable) begin
                if (terminal) begin
                    cnt     <= '0;
                    clk_out <= ~clk_out;
                    tick    <= ~clk_out;
                    if (clk_out && pend) begin
                        half <= pending;
                    end
                end else begin
                    cnt  <= cnt + CNT_W'(1);
                    tick <= 1'b0;
                end
            end else begin
                tick <= 1'b0;
            end

            // A same-cycle write lands after the old pending value has been consumed
            if (wr) begin
                pending <= wr_val;
                pend    <= 1'b1;
            end else if (sync_req || apply_edge) begin
                pend <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/multi_rate_divider.sv
// rtl/multi_rate_divider.sv - NUM_CH independent divided clocks with write decode and error strobe
module multi_rate_divider
    import multi_rate_divider_pkg::*;
#(
    parameter int                          NUM_CH   = NUM_CH_DEF,
    parameter int                          CNT_W    = CNT_W_DEF,
    parameter logic [NUM_CH*CNT_W-1:0]     DEF_HALF = DEF_HALF_DEF,
    localparam int                         SEL_W    = sel_width(NUM_CH)
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              enable,
    input  logic              sync_req,
    input  logic              div_wr,
    input  logic [SEL_W-1:0]  div_sel,
    input  logic [CNT_W-1:0]  div_val,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pend,
    output logic              wr_err
);

    localparam int CH_LIM = (NUM_CH < NUM_CH_MAX) ? NUM_CH : NUM_CH_MAX;

    logic wr_ok;
    logic wr_bad;

    assign wr_ok  = div_wr && (div_val != '0) && (int'(div_sel) < CH_LIM);
    assign wr_bad = div_wr && !wr_ok;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            wr_err <= 1'b0;
        end else begin
            wr_err <= wr_bad;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic ch_wr;

        assign ch_wr = wr_ok && (int'(div_sel) == i);

        div_channel #(
            .CNT_W    (CNT_W),
            .RST_HALF (DEF_HALF[i*CNT_W +: CNT_W])
        ) u_ch (
            .clk_in   (clk_in),
            .reset    (reset),
            .enable   (enable),
            .sync_req (sync_req),
            .wr       (ch_wr),
            .wr_val   (div_val),
            .clk_out  (clk_out[i]),
            .tick     (tick[i]),
            .pend     (pend[i])
        );
    end

endmodule
